ram_loader: RTL and testbench

//  Byte-stream boot loader that sits directly upstream of the dual-port program/data RAM write port.

---
 rtl/ram_loader_pkg.sv | 21 ++
 rtl/ram_loader_if.sv | 35 +++
 rtl/ram_loader_asm.sv | 39 +++
 rtl/ram_loader.sv | 174 +++++++++++++++++
 tb/tb_ram_loader.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_loader_pkg.sv
// ram_loader shared types: FSM state encoding, sync byte default,
// length field width.
package ram_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_H,
    S_LEN_L,
    S_LEN_CK,
    S_DAT_H,
    S_DAT_L,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] SYNC_DEF = 8'hA5;
  localparam int         LEN_W    = 16;

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader bus: byte stream in (valid/ready) plus RAM write port.
// master = loader side, slave = byte source / RAM side.
interface ram_loader_if #(
  parameter int ADR_WIDTH = 11
);

  logic [7:0]           in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mem_en;
  logic                 mem_we;
  logic [ADR_WIDTH-1:0] mem_adr;
  logic [15:0]          mem_dat;

  modport master (
    input  in_data,
    input  in_valid,
    output in_ready,
    output mem_en,
    output mem_we,
    output mem_adr,
    output mem_dat
  );

  modport slave (
    output in_data,
    output in_valid,
    input  in_ready,
    input  mem_en,
    input  mem_we,
    input  mem_adr,
    input  mem_dat
  );

endinterface

// File: rtl/ram_loader_asm.sv
// ram_loader_asm: hi/lo byte assembler and XOR checksum accumulator.
// Accumulator exists only with RAM_LOADER_CHKSUM_EN.
module ram_loader_asm (
  input  logic        clk,
  input  logic        rst_n,
`ifdef RAM_LOADER_CHKSUM_EN
  input  logic        clr,
  output logic [7:0]  sum,
`endif
  input  logic        lat_hi,
  input  logic        lat_lo,
  input  logic [7:0]  data,
  output logic [15:0] word
);

  // capture big-endian word halves
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
    end else begin
      if (lat_hi) word[15:8] <= data;
      if (lat_lo) word[7:0]  <= data;
    end
  end

`ifdef RAM_LOADER_CHKSUM_EN
  // running XOR of every data byte in the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clr) begin
      sum <= '0;
    end else if (lat_hi || lat_lo) begin
      sum <= sum ^ data;
    end
  end
`endif

endmodule

// File: rtl/ram_loader.sv
// ram_loader: framed byte stream to RAM word writer, holds core in reset.
// Optional CHK byte checking enabled by RAM_LOADER_CHKSUM_EN.
import ram_loader_pkg::*;

module ram_loader #(
  parameter int         ADR_WIDTH = 11,
  parameter int         BASE_ADR  = 0,
  parameter logic [7:0] SYNC_BYTE = SYNC_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_loader_if.master bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);

  localparam int unsigned DEPTH = 1 << ADR_WIDTH;
  localparam logic [LEN_W:0] CAP =
    (LEN_W+1)'(DEPTH - BASE_ADR);
  localparam logic [ADR_WIDTH-1:0] BASE =
    ADR_WIDTH'(BASE_ADR);

`ifdef RAM_LOADER_CHKSUM_EN
  localparam state_t S_TAIL = S_CHK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t               state, state_n;
  logic [LEN_W-1:0]     rem;
  logic [ADR_WIDTH-1:0] addr;
  logic                 rdy_q, wen_q;
  logic                 take, is_sync;
  logic                 start, ld_lh, ld_ll;
  logic                 lat_hi, lat_lo, step;
  logic                 fin_ok, fin_err;
  logic [15:0]          word;
`ifdef RAM_LOADER_CHKSUM_EN
  logic [7:0]           sum;
`endif

  assign take    = bus.in_valid & rdy_q;
  assign is_sync = bus.in_data == SYNC_BYTE;

  assign bus.in_ready = rdy_q;
  assign bus.mem_en   = wen_q;
  assign bus.mem_we   = wen_q;
  assign bus.mem_adr  = addr;
  assign bus.mem_dat  = word;

  ram_loader_asm u_asm (
    .clk    (clk),
    .rst_n  (rst_n),
`ifdef RAM_LOADER_CHKSUM_EN
    .clr    (start),
    .sum    (sum),
`endif
    .lat_hi (lat_hi),
    .lat_lo (lat_lo),
    .data   (bus.in_data),
    .word   (word)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // next state and one-cycle control strobes
  always_comb begin
    state_n = state;
    start   = 1'b0;
    ld_lh   = 1'b0;
    ld_ll   = 1'b0;
    lat_hi  = 1'b0;
    lat_lo  = 1'b0;
    step    = 1'b0;
    unique case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (take && is_sync) begin
          state_n = S_LEN_H;
          start   = 1'b1;
        end
      end
      S_LEN_H: begin
        if (take) begin
          state_n = S_LEN_L;
          ld_lh   = 1'b1;
        end
      end
      S_LEN_L: begin
        if (take) begin
          state_n = S_LEN_CK;
          ld_ll   = 1'b1;
        end
      end
      S_LEN_CK: begin
        if (rem == '0)
          state_n = S_TAIL;
        else if ({1'b0, rem} > CAP)
          state_n = S_ERR;
        else
          state_n = S_DAT_H;
      end
      S_DAT_H: begin
        if (take) begin
          state_n = S_DAT_L;
          lat_hi  = 1'b1;
        end
      end
      S_DAT_L: begin
        if (take) begin
          state_n = S_WRITE;
          lat_lo  = 1'b1;
        end
      end
      S_WRITE: begin
        step = 1'b1;
        if (rem == LEN_W'(1)) state_n = S_TAIL;
        else                  state_n = S_DAT_H;
      end
      S_CHK: begin
`ifdef RAM_LOADER_CHKSUM_EN
        if (take) begin
          if (bus.in_data == sum) state_n = S_DONE;
          else                    state_n = S_ERR;
        end
`else
        state_n = S_IDLE;
`endif
      end
      default: state_n = S_IDLE;
    endcase
    fin_ok  = (state_n == S_DONE) && (state != S_DONE);
    fin_err = (state_n == S_ERR) && (state != S_ERR);
  end

  // counters, registered handshake and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      addr     <= BASE;
      rdy_q    <= 1'b1;
      wen_q    <= 1'b0;
      cpu_hold <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      rdy_q <= !(state_n inside {S_WRITE, S_LEN_CK});
      wen_q <= state_n == S_WRITE;
      if (start) begin
        addr     <= BASE;
        cpu_hold <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
      end
      if (ld_lh) rem[15:8] <= bus.in_data;
      if (ld_ll) rem[7:0]  <= bus.in_data;
      // last word keeps addr on itself so it never wraps
      if (step) begin
        rem <= rem - LEN_W'(1);
        if (rem != LEN_W'(1)) addr <= addr + ADR_WIDTH'(1);
      end
      if (fin_ok) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (fin_err) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: table vectors, random frames vs frame-level model,
// mid-frame reset sequence.
module tb_ram_loader;

  localparam int         AW    = 6;
  localparam int         DEPTH = 1 << AW;
  localparam int         BASE  = 0;
  localparam logic [7:0] SYNC  = 8'hA5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_hold, done, err;

  always #5 clk = ~clk;

  ram_loader_if #(.ADR_WIDTH(AW)) bus ();

  ram_loader #(
    .ADR_WIDTH (AW),
    .BASE_ADR  (BASE),
    .SYNC_BYTE (SYNC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [AW-1:0] wa_q[$];
  logic [15:0]   wd_q[$];
  int            rdy_lo = 0;
  int            we_bad = 0;

  always @(negedge clk) begin
    if (bus.mem_en === 1'b1) begin
      wa_q.push_back(bus.mem_adr);
      wd_q.push_back(bus.mem_dat);
    end
    if (bus.in_ready !== 1'b1) rdy_lo <= rdy_lo + 1;
    if (bus.mem_we !== bus.mem_en) we_bad <= we_bad + 1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int          m_wa[$];
  logic [15:0] m_wd[$];
  bit          m_done, m_err, m_hold;
  int          m_adr, m_lo;

  // frame-level reference: parse the byte list by position
  task automatic model(input logic [7:0] q[$]);
    int i;
    int len;
    logic [7:0] x;
    m_wa.delete();
    m_wd.delete();
    m_lo = 0;
    i = 0;
    while (i < q.size()) begin
      if (q[i] != SYNC) begin
        i++;
        continue;
      end
      len = {q[i+1], q[i+2]};
      i += 3;
      m_done = 0;
      m_err = 0;
      m_hold = 1;
      m_adr = BASE;
      m_lo++;
      if (len > DEPTH - BASE) begin
        m_err = 1;
        continue;
      end
      x = 8'h00;
      for (int w = 0; w < len; w++) begin
        m_wa.push_back(BASE + w);
        m_wd.push_back({q[i], q[i+1]});
        x = x ^ q[i] ^ q[i+1];
        i += 2;
        m_lo++;
        m_adr = BASE + w;
      end
`ifdef RAM_LOADER_CHKSUM_EN
      if (q[i] == x) begin
        m_done = 1;
        m_hold = 0;
      end else begin
        m_err = 1;
      end
      i++;
`else
      m_done = 1;
      m_hold = 0;
`endif
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int n;
    n = 0;
    while (stall && $urandom_range(0, 1) == 0) begin
      bus.in_valid = 1'b0;
      bus.in_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data = b;
    while (1) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      n++;
      if (n > 50) break;
    end
    if (n > 50) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: byte %0h not taken", b);
    end else begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input string nm,
                           input logic [7:0] q[$],
                           input bit stall);
    int w0, r0, nw;
    w0 = wa_q.size();
    r0 = rdy_lo;
    model(q);
    foreach (q[k]) send_byte(q[k], stall);
    repeat (4) @(posedge clk);
    #1;
    nw = wa_q.size() - w0;
    chk({nm, ".nwr"}, nw, m_wa.size());
    for (int k = 0; k < nw && k < m_wa.size(); k++) begin
      chk({nm, ".wadr"}, wa_q[w0+k], m_wa[k]);
      chk({nm, ".wdat"}, wd_q[w0+k], m_wd[k]);
    end
    chk({nm, ".done"}, done, m_done);
    chk({nm, ".err"}, err, m_err);
    chk({nm, ".hold"}, cpu_hold, m_hold);
    chk({nm, ".adr"}, bus.mem_adr, m_adr);
    chk({nm, ".rdy_lo"}, rdy_lo - r0, m_lo);
    chk({nm, ".rdy"}, bus.in_ready, 1);
    chk({nm, ".en"}, bus.mem_en, 0);
  endtask

  task automatic build(input int len, input bit good,
                       output logic [7:0] q[$]);
    logic [7:0] x, b;
    q.delete();
    q.push_back(SYNC);
    q.push_back(8'(len >> 8));
    q.push_back(8'(len));
    x = 8'h00;
    for (int i = 0; i < 2 * len; i++) begin
      b = 8'($urandom);
      q.push_back(b);
      x = x ^ b;
    end
`ifdef RAM_LOADER_CHKSUM_EN
    if (!good) x = x ^ 8'($urandom_range(1, 255));
    q.push_back(x);
`else
    if (!good) q.push_back(8'h3C);
`endif
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, ".rdy"}, bus.in_ready, 1);
    chk({nm, ".en"}, bus.mem_en, 0);
    chk({nm, ".we"}, bus.mem_we, 0);
    chk({nm, ".adr"}, bus.mem_adr, BASE);
    chk({nm, ".dat"}, bus.mem_dat, 0);
    chk({nm, ".hold"}, cpu_hold, 1);
    chk({nm, ".done"}, done, 0);
    chk({nm, ".err"}, err, 0);
  endtask

  typedef struct {
    string      name;
    int         n;
    logic [7:0] b [12];
    bit         e_done;
    bit         e_err;
    int         e_nwr;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    logic [7:0] tail [6];
    int w0;

`ifdef RAM_LOADER_CHKSUM_EN
    tbl[0] = '{"basic", 8, '{8'hA5, 8'h00, 8'h02, 8'h12,
               8'h34, 8'hAB, 8'hCD, 8'h40, 8'h00, 8'h00,
               8'h00, 8'h00}, 1'b1, 1'b0, 2};
    tbl[1] = '{"badchk", 8, '{8'hA5, 8'h00, 8'h02, 8'h12,
               8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, 1'b0, 1'b1, 2};
    tbl[3] = '{"lead", 7, '{8'h00, 8'hFF, 8'h5A, 8'hA5,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, 1'b1, 1'b0, 0};
    tbl[4] = '{"syncdat", 6, '{8'hA5, 8'h00, 8'h01, 8'hA5,
               8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, 1'b1, 1'b0, 1};
`else
    tbl[0] = '{"basic", 7, '{8'hA5, 8'h00, 8'h02, 8'h12,
               8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, 1'b1, 1'b0, 2};
    tbl[1] = '{"trail", 6, '{8'hA5, 8'h00, 8'h01, 8'h12,
               8'h34, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, 1'b1, 1'b0, 1};
    tbl[3] = '{"lead", 6, '{8'h00, 8'hFF, 8'h5A, 8'hA5,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, 1'b1, 1'b0, 0};
    tbl[4] = '{"syncdat", 5, '{8'hA5, 8'h00, 8'h01, 8'hA5,
               8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, 1'b1, 1'b0, 1};
`endif
    tbl[2] = '{"lenover", 3, '{8'hA5, 8'h00, 8'h41, 8'h00,
               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h00}, 1'b0, 1'b1, 0};

    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[t]) begin
      w0 = wa_q.size();
      q.delete();
      for (int k = 0; k < tbl[t].n; k++) q.push_back(tbl[t].b[k]);
      run_frame(tbl[t].name, q, 1'b0);
      chk({tbl[t].name, ".c_done"}, done, tbl[t].e_done);
      chk({tbl[t].name, ".c_err"}, err, tbl[t].e_err);
      chk({tbl[t].name, ".c_hold"}, cpu_hold, !tbl[t].e_done);
      chk({tbl[t].name, ".c_nwr"}, wa_q.size() - w0, tbl[t].e_nwr);
    end

    build(DEPTH, 1'b1, q);
    run_frame("full", q, 1'b0);
    chk("full.c_adr", bus.mem_adr, DEPTH - 1);

    build(64, 1'b1, q);
    run_frame("stall64", q, 1'b1);

    for (int r = 0; r < 6; r++) begin
      build($urandom_range(0, 20), $urandom_range(0, 3) != 0, q);
      run_frame("rand", q, 1'b1);
    end

    w0 = wa_q.size();
    q = '{SYNC, 8'h00, 8'h04, 8'hDE, 8'hAD};
    foreach (q[k]) send_byte(q[k], 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst.pre_nwr", wa_q.size() - w0, 1);
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    w0 = wa_q.size();
    tail = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    foreach (tail[k]) send_byte(tail[k], 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst.post_nwr", wa_q.size() - w0, 0);
    chk("midrst.post_hold", cpu_hold, 1);
    chk("midrst.post_done", done, 0);
    build(4, 1'b1, q);
    run_frame("fresh", q, 1'b1);

    chk("we_eq_en", we_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
